dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Sequencer and two-port arbiter for the single-port data memory `d_mem`. It shares the memory between the processor MEM stage (`cpu_*`) and a debug/loader port (`dbg_*`), runs each access as a fixed three-state transaction, and returns read data with a registered one-cycle acknowledge. It also range-checks addresses so that out-of-range accesses never reach the RAM array.

## Interface
- `MEM_WORDS`, default 8: number of 32-bit words in `d_mem`. Valid word addresses are 0..MEM_WORDS-1.
- `ADDR_W`, default 32: address width passed through to `d_mem`.

Ports (name, direction, width, meaning):
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request, level.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: word address.
- `cpu_wdata` in 32: write data.
- `cpu_rdata` out 32: read data, valid while `cpu_ack` is high.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_stall` out 1: `cpu_req & ~cpu_ack`, combinational; freezes the pipeline.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_ack`: same meanings and widths as the `cpu_*` signals, for the debug port.
- `err` out 1: pulses together with the ack when the completed access was out of range.
- `mem_write` out 1: drives `d_mem` MemWrite.
- `mem_read` out 1: drives `d_mem` MemRead.
- `mem_addr` out ADDR_W: drives `d_mem` Address.
- `mem_wdata` out 32: drives `d_mem` WriteData.
- `mem_rdata` in 32: from `d_mem` ReadData.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE -> ACCESS when any request is high.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- Requests are sampled only in IDLE. On the IDLE->ACCESS edge, the winner's id, `we`, `addr` and `wdata` are latched into internal registers.
- Arbitration is round-robin using a `last_grant` register.
  - If only one port requests, that port wins.
  - If both request, the port not equal to `last_grant` wins.
  - `last_grant` updates on each grant.
  - Reset value of `last_grant` is DBG, so the CPU wins the first tie.
- ACCESS state drives `d_mem` from the latched registers:
  - `mem_addr` = latched addr and `mem_wdata` = latched wdata.
  - `mem_write` = latched `we` & in_range.
  - `mem_read` = ~latched `we` & in_range.
  - `mem_rdata` is captured into an rdata register at the end of ACCESS.
- Range check: in_range = (latched addr < MEM_WORDS), computed as an unsigned compare on the full ADDR_W bits. When out of range:
  - no strobe is asserted;
  - the captured rdata is 0;
  - `err` pulses in RESP.
- RESP state:
  - The granted port's ack is high for exactly one cycle.
  - The granted port's rdata output shows the rdata register; for writes this is 0.
  - The other port's ack stays low.
- Outside ACCESS, `mem_write`, `mem_read`, `mem_addr` and `mem_wdata` are all 0.
- Each port's rdata output is 0 whenever its ack is low.
- A requester must drop `req` in the cycle after its ack. A `req` still high in the following IDLE is treated as a new transaction.
- If a requester drops `req` after the grant, the latched transaction still completes and the ack still pulses.
- Reset, including reset asserted mid-transaction:
  - All outputs go to 0 immediately, state -> IDLE, `last_grant` -> DBG.
  - No ack is issued for the aborted transaction.
  - Memory contents at an address being written when reset hits are undefined.

## Timing
- A request seen at edge k gives ACCESS in cycle k+1 and ack in cycle k+2. Latency is 2 cycles from sampling to ack.
- Throughput is one transaction per 3 cycles, since IDLE is always visited between transactions.
- With both ports requesting continuously, grants alternate CPU, DBG, CPU, …
- The worst-case CPU wait with debug contending is 5 cycles.
- All outputs are registered or decoded from registered state, except `cpu_stall`.

## Structure
- Shared header `dmem_defs.vh` holds:
  - state encodings: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - requester ids: ID_CPU=1'b0, ID_DBG=1'b1;
  - the default MEM_WORDS.
- One sub-module, `rr_arb2`, is the natural split: a two-input round-robin picker (inputs `req[1:0]` and `last`; output `grant_id`).
- Expected RTL size is roughly 150–200 lines.

## Test plan
- Reset, then CPU write of 32'hDEADBEEF to addr 3, then CPU read of addr 3: `mem_write` is high for exactly one cycle with `mem_addr`=3; the read returns `cpu_rdata`=32'hDEADBEEF with `cpu_ack` 2 cycles after sampling; `err`=0.
- CPU and DBG both raise `req` at the same edge just after reset: CPU is served first and DBG acks 3 cycles later. Holding both requests high shows grants strictly alternating over 6 transactions.
- DBG read of addr 8 with MEM_WORDS=8: `mem_read` and `mem_write` stay 0 throughout; `dbg_rdata`=0; `err` and `dbg_ack` pulse together.
- DBG write of 32'h12345678 to addr 7 while the CPU is stalled on a read of addr 7: `cpu_stall` stays high until the CPU ack; the CPU read returns 32'h12345678.
- `reset_n` asserted during ACCESS of a CPU write: all `mem_*` signals go to 0 asynchronously, no `cpu_ack` appears, and after release the FSM is in IDLE with the CPU winning the next tie.
- CPU drops `req` one cycle after the grant: `cpu_ack` still pulses once, and no second transaction starts.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the d_mem sequencer/arbiter: FSM states, requester ids,
// and the default memory depth.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        ID_CPU = 1'b0,
        ID_DBG = 1'b1
    } req_id_e;

    localparam int unsigned MEM_WORDS_DEFAULT = 8;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,      // [0] = CPU, [1] = DBG
    input  req_id_e    last,
    output req_id_e    grant_id
);

    always_comb begin
        grant_id = ID_CPU;
        case (req)
            2'b10:   grant_id = ID_DBG;
            2'b11:   grant_id = (last == ID_CPU) ? ID_DBG : ID_CPU;
            default: grant_id = ID_CPU;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port d_mem between the CPU MEM stage and a debug/loader port,
// running each access as IDLE -> ACCESS -> RESP with range-checked addresses.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_ack,

    output logic              err,

    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    req_id_e           gid_q, gid_d;
    req_id_e           last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    req_id_e           pick;
    logic              in_access;
    logic              in_resp;
    logic              in_range;

    rr_arb2 u_rr_arb2 (
        .req      ({dbg_req, cpu_req}),
        .last     (last_q),
        .grant_id (pick)
    );

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);
    assign in_range  = (addr_q < ADDR_W'(MEM_WORDS));

    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    state_d = ACCESS;
                    gid_d   = pick;
                    last_d  = pick;
                    if (pick == ID_DBG) begin
                        we_d    = dbg_we;
                        addr_d  = dbg_addr;
                        wdata_d = dbg_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                // Writes and out-of-range accesses both return zero.
                rdata_d = mem_read ? mem_rdata : '0;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gid_q   <= ID_CPU;
            last_q  <= ID_DBG;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_write = in_access & we_q & in_range;
    assign mem_read  = in_access & ~we_q & in_range;
    assign mem_addr  = in_access ? addr_q : '0;
    assign mem_wdata = in_access ? wdata_q : '0;

    assign cpu_ack   = in_resp & (gid_q == ID_CPU);
    assign dbg_ack   = in_resp & (gid_q == ID_DBG);
    assign cpu_rdata = cpu_ack ? rdata_q : '0;
    assign dbg_rdata = dbg_ack ? rdata_q : '0;
    assign err       = in_resp & ~in_range;

    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a behavioural d_mem model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MEM_WORDS = 8;
    localparam logic        P_CPU     = 1'b0;
    localparam logic        P_DBG     = 1'b1;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack, cpu_stall;
    logic              dbg_req = 1'b0, dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [31:0]       dbg_wdata = '0;
    logic [31:0]       dbg_rdata;
    logic              dbg_ack;
    logic              err, mem_write, mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    logic [31:0] tb_mem [MEM_WORDS] = '{default: 32'h0};

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        dbg_q[$];
    exp_t        mon_e;
    logic        grant_log[$];
    int          checks = 0;
    int          failures = 0;
    int          wr_cycles = 0;
    int          rd_cycles = 0;
    logic [31:0] wr_addr = '0;
    int          cpu_acks = 0;
    int          dbg_acks = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_ack   (dbg_ack),
        .err       (err),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // d_mem model: synchronous write, combinational read; garbage beyond the array.
    always @(posedge clock)
        if (mem_write && mem_addr < MEM_WORDS) tb_mem[mem_addr[2:0]] <= mem_wdata;
    assign mem_rdata = (mem_addr < MEM_WORDS) ? tb_mem[mem_addr[2:0]] : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: pops the per-port scoreboard whenever an ack is presented.
    always @(negedge clock) begin
        if (mem_write) begin
            wr_cycles++;
            wr_addr = mem_addr;
        end
        if (mem_read) rd_cycles++;
        if (err && !(cpu_ack || dbg_ack)) check1("err_without_ack", err, 1'b0);
        if (cpu_ack && dbg_ack) check1("dual_ack", dbg_ack, 1'b0);
        if (cpu_ack) begin
            cpu_acks++;
            grant_log.push_back(P_CPU);
            if (cpu_q.size() == 0) check1("cpu_unexpected_ack", cpu_ack, 1'b0);
            else begin
                mon_e = cpu_q.pop_front();
                check("cpu_rdata", cpu_rdata, mon_e.rdata);
                check1("cpu_err", err, mon_e.err);
                check("dbg_rdata_while_idle", dbg_rdata, 32'h0);
            end
        end
        if (dbg_ack) begin
            dbg_acks++;
            grant_log.push_back(P_DBG);
            if (dbg_q.size() == 0) check1("dbg_unexpected_ack", dbg_ack, 1'b0);
            else begin
                mon_e = dbg_q.pop_front();
                check("dbg_rdata", dbg_rdata, mon_e.rdata);
                check1("dbg_err", err, mon_e.err);
                check("cpu_rdata_while_idle", cpu_rdata, 32'h0);
            end
        end
    end

    // Issues n back-to-back transactions on one port with req held high, then drops req.
    // exp_lat is sampling-to-ack latency of the first transaction (0 = not checked).
    task automatic run_port(input logic port, input int n, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input int exp_lat);
        exp_t e;
        int   lat;
        bit   got;
        bit   stall_bad;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        if (port == P_DBG) begin
            dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        for (int t = 0; t < n; t++) begin
            if (port == P_DBG) dbg_q.push_back(e);
            else cpu_q.push_back(e);
            got = 1'b0;
            lat = 0;
            stall_bad = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clock);
                lat++;
                if ((port == P_DBG) ? dbg_ack : cpu_ack) got = 1'b1;
                else if (port == P_CPU && !cpu_stall) stall_bad = 1'b1;
            end
            if (!got) begin
                check1("ack_timeout", got, 1'b1);
                if (port == P_DBG) void'(dbg_q.pop_back());
                else void'(cpu_q.pop_back());
            end else begin
                if (port == P_CPU) begin
                    check1("cpu_stall_while_waiting_low", stall_bad, 1'b0);
                    check1("cpu_stall_at_ack", cpu_stall, 1'b0);
                end
                // first negedge after raising req precedes the sampling edge
                if (t == 0 && exp_lat != 0) check("latency", 32'(lat - 1), 32'(exp_lat));
            end
            @(posedge clock);
            #1;
        end
        if (port == P_DBG) dbg_req = 1'b0;
        else cpu_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic check_grants(input int g0, input int n);
        check("grant_count", 32'(grant_log.size() - g0), 32'(n));
        for (int i = 0; i < n && g0 + i < grant_log.size(); i++)
            check1("grant_order", grant_log[g0 + i], (i % 2) != 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int w0, r0, a0, g0;

        // Reset state
        #23;
        check1("rst_cpu_ack", cpu_ack, 1'b0);
        check1("rst_dbg_ack", dbg_ack, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_mem_write", mem_write, 1'b0);
        check1("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check1("rst_cpu_stall", cpu_stall, 1'b0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // CPU write then read of addr 3
        w0 = wr_cycles; r0 = rd_cycles;
        run_port(P_CPU, 1, 1'b1, 32'd3, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        check("wr_one_cycle", 32'(wr_cycles - w0), 32'd1);
        check("wr_addr", wr_addr, 32'd3);
        check("wr_no_read", 32'(rd_cycles - r0), 32'd0);
        w0 = wr_cycles; r0 = rd_cycles;
        run_port(P_CPU, 1, 1'b0, 32'd3, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        check("rd_one_cycle", 32'(rd_cycles - r0), 32'd1);
        check("rd_no_write", 32'(wr_cycles - w0), 32'd0);

        // DBG write of addr 7 while the CPU is stalled reading addr 7
        fork
            run_port(P_DBG, 1, 1'b1, 32'd7, 32'h12345678, 32'h0, 1'b0, 2);
            begin
                @(posedge clock);
                #1;
                run_port(P_CPU, 1, 1'b0, 32'd7, 32'h0, 32'h12345678, 1'b0, 4);
            end
        join

        // DBG read just past the end of memory
        w0 = wr_cycles; r0 = rd_cycles;
        run_port(P_DBG, 1, 1'b0, 32'd8, 32'h0, 32'h0, 1'b1, 2);
        check("oor_no_read", 32'(rd_cycles - r0), 32'd0);
        check("oor_no_write", 32'(wr_cycles - w0), 32'd0);
        run_port(P_CPU, 1, 1'b1, 32'hFFFF_FFFF, 32'h5555AAAA, 32'h0, 1'b1, 2);
        check("oor_wr_no_write", 32'(wr_cycles - w0), 32'd0);

        // Tie just after reset, then six alternating grants
        do_reset();
        g0 = grant_log.size();
        fork
            run_port(P_CPU, 1, 1'b0, 32'd3, 32'h0, 32'hDEADBEEF, 1'b0, 2);
            run_port(P_DBG, 1, 1'b0, 32'd7, 32'h0, 32'h12345678, 1'b0, 5);
        join
        check_grants(g0, 2);
        g0 = grant_log.size();
        fork
            run_port(P_CPU, 3, 1'b0, 32'd3, 32'h0, 32'hDEADBEEF, 1'b0, 0);
            run_port(P_DBG, 3, 1'b0, 32'd7, 32'h0, 32'h12345678, 1'b0, 0);
        join
        check_grants(g0, 6);

        // Reset asserted during ACCESS of a CPU write
        a0 = cpu_acks;
        cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'hAAAA5555; cpu_req = 1'b1;
        @(posedge clock);
        #2;
        check1("pre_rst_mem_write", mem_write, 1'b1);
        reset_n = 1'b0;
        #1;
        check1("async_rst_mem_write", mem_write, 1'b0);
        check1("async_rst_mem_read", mem_read, 1'b0);
        check("async_rst_mem_addr", mem_addr, 32'h0);
        check("async_rst_mem_wdata", mem_wdata, 32'h0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("no_ack_after_abort", 32'(cpu_acks - a0), 32'd0);
        g0 = grant_log.size();
        fork
            run_port(P_CPU, 1, 1'b0, 32'd3, 32'h0, 32'hDEADBEEF, 1'b0, 2);
            run_port(P_DBG, 1, 1'b0, 32'd7, 32'h0, 32'h12345678, 1'b0, 5);
        join
        check_grants(g0, 2);

        // CPU drops req right after the grant
        a0 = cpu_acks; r0 = rd_cycles;
        cpu_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
        cpu_we = 1'b0; cpu_addr = 32'd3; cpu_req = 1'b1;
        @(posedge clock);
        #1 cpu_req = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("drop_req_one_ack", 32'(cpu_acks - a0), 32'd1);
        check("drop_req_one_read", 32'(rd_cycles - r0), 32'd1);
        check("scoreboard_drained", 32'(cpu_q.size() + dbg_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
